// File: rtl/axi_status_register.sv
// -----------------------------------------------------------------------------
// axi_status_register
//
// AXI4-Lite read-only slave that exposes a wide, flat status vector as
// consecutive 32-bit words. Fabric logic drives sts_data; software reads any
// word through the AXI read channel. Only one read is outstanding at a time,
// so back-to-back throughput is one read every two cycles.
//
// Optional feature macro: AXI_STS_ADDR_CHECK_EN
//   undefined (default): upper address bits are ignored and addresses wrap
//                        modulo WORDS*4; rresp is always OKAY.
//   defined            : an accepted address >= WORDS*4 (full address width)
//                        returns rresp=SLVERR with rdata=0.
// -----------------------------------------------------------------------------
module axi_status_register #(
    parameter int STS_DATA_WIDTH = 1024,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [STS_DATA_WIDTH-1:0] sts_data,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    // Derived geometry of the status window.
    localparam int WORDS      = STS_DATA_WIDTH / AXI_DATA_WIDTH;
    localparam int ADDR_BITS  = $clog2(WORDS);
    localparam int WORD_SHIFT = $clog2(AXI_DATA_WIDTH);
    localparam int BASE_W     = ADDR_BITS + WORD_SHIFT;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Read-data holding register and handshake state.
    logic                      rvalid_r;
    logic [AXI_DATA_WIDTH-1:0] rdata_r;
    logic [1:0]                rresp_r;

    // Address decode and next-response values.
    logic                      arready_s;
    logic                      accept_s;
    logic                      complete_s;
    logic [ADDR_BITS-1:0]      word_idx_s;
    logic [BASE_W-1:0]         word_base_s;
    logic [AXI_DATA_WIDTH-1:0] sel_word_s;
    logic [AXI_DATA_WIDTH-1:0] rdata_nxt_s;
    logic [1:0]                rresp_nxt_s;
    logic                      unused_addr_s;

    // The byte lane bits and the bits above the word index never select data;
    // they are folded here so they are visibly consumed.
    assign unused_addr_s = ^{s_axi_araddr[AXI_ADDR_WIDTH-1:ADDR_BITS+2],
                             s_axi_araddr[1:0]};

    // Ready only when no response is pending, and never while in reset.
    assign arready_s  = ~rvalid_r & ~areset;
    assign accept_s   = s_axi_arvalid & arready_s;
    assign complete_s = rvalid_r & s_axi_rready;

    // Word index from the byte address; sub-word bits are dropped so an
    // unaligned address reads its containing word.
    assign word_idx_s  = s_axi_araddr[ADDR_BITS+1:2];
    assign word_base_s = {word_idx_s, {WORD_SHIFT{1'b0}}};

`ifdef AXI_STS_ADDR_CHECK_EN
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LIMIT =
        AXI_ADDR_WIDTH'(WORDS * (AXI_DATA_WIDTH / 8));

    logic addr_err_s;

    // Any address beyond the status window is flagged, not wrapped.
    assign addr_err_s = (s_axi_araddr >= ADDR_LIMIT);
`endif

    // Select the addressed 32-bit word out of the flat status vector.
    always_comb begin
        sel_word_s = sts_data[word_base_s +: AXI_DATA_WIDTH];
    end

    // Build the response that will be captured on an accepting edge.
    always_comb begin
        rdata_nxt_s = sel_word_s;
        rresp_nxt_s = RESP_OKAY;
`ifdef AXI_STS_ADDR_CHECK_EN
        if (addr_err_s) begin
            rdata_nxt_s = {AXI_DATA_WIDTH{1'b0}};
            rresp_nxt_s = RESP_SLVERR;
        end else begin
            rdata_nxt_s = sel_word_s;
            rresp_nxt_s = RESP_OKAY;
        end
`endif
    end

    // Read response channel: capture on accept, hold under backpressure,
    // release rvalid on the handshake; rdata keeps its last value afterwards.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rvalid_r <= 1'b0;
            rdata_r  <= {AXI_DATA_WIDTH{1'b0}};
            rresp_r  <= RESP_OKAY;
        end else if (accept_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rdata_nxt_s;
            rresp_r  <= rresp_nxt_s;
        end else if (complete_s) begin
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= rvalid_r;
        end
    end

    assign s_axi_arready = arready_s;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = rresp_r;

endmodule

// File: tb/tb_axi_status_register.sv
// -----------------------------------------------------------------------------
// Self-checking bench for axi_status_register: directed vector table, hand
// sequences for backpressure / reset / back-to-back, and randomized reads
// compared against a word-array reference model.
// -----------------------------------------------------------------------------
module tb_axi_status_register;

    localparam int STS_W = 1024;
    localparam int AW    = 32;
    localparam int WORDS = STS_W / 32;

    logic              aclk = 1'b0;
    logic              areset;
    logic [STS_W-1:0]  sts_data;
    logic [AW-1:0]     araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    logic [31:0] words [WORDS];

    int errors = 0;
    int checks = 0;

    axi_status_register #(
        .STS_DATA_WIDTH(STS_W),
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(AW)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .sts_data     (sts_data),
        .s_axi_araddr (araddr),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready)
    );

    always #5 aclk = ~aclk;

    // Pack the model word array into the flat status vector.
    always_comb begin
        sts_data = '0;
        for (int k = 0; k < WORDS; k++) sts_data[k*32 +: 32] = words[k];
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: byte address -> word, wrapping modulo the window unless the
    // range check is built in.
    function automatic logic [31:0] model_data(input logic [31:0] addr);
`ifdef AXI_STS_ADDR_CHECK_EN
        if (addr >= 32'(WORDS * 4)) return 32'd0;
`endif
        return words[(addr / 4) % WORDS];
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] addr);
`ifdef AXI_STS_ADDR_CHECK_EN
        if (addr >= 32'(WORDS * 4)) return 2'b10;
`endif
        return 2'b00;
    endfunction

    // One complete read with 'hold' cycles of rready=0 after rvalid.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_d,
                           input logic [1:0] exp_r, input int hold,
                           input bit scramble, input string tag);
        @(negedge aclk);
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b0;
        check({tag, ".arready_idle"}, 32'(arready), 32'd1);
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
        araddr  = $urandom;
        @(negedge aclk);
        check({tag, ".rvalid"}, 32'(rvalid), 32'd1);
        check({tag, ".rdata"}, rdata, exp_d);
        check({tag, ".rresp"}, 32'(rresp), 32'(exp_r));
        for (int h = 0; h < hold; h++) begin
            if (scramble) words[$urandom_range(0, WORDS-1)] = $urandom;
            arvalid = 1'b1;
            @(negedge aclk);
            check({tag, ".hold_rvalid"}, 32'(rvalid), 32'd1);
            check({tag, ".hold_rdata"}, rdata, exp_d);
            check({tag, ".hold_arready"}, 32'(arready), 32'd0);
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        @(posedge aclk);
        #1;
        rready = 1'b0;
        @(negedge aclk);
        check({tag, ".done_rvalid"}, 32'(rvalid), 32'd0);
        check({tag, ".done_arready"}, 32'(arready), 32'd1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        string       name;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [31:0] a;
        logic [31:0] ed;
        logic [1:0]  er;
        logic [31:0] b2b_addr [8];

        vecs[0] = '{32'h0000_0004, 32'h3344_5566, 2'b00, "rd_0x04"};
        vecs[1] = '{32'h0000_0060, 32'h1122_3344, 2'b00, "rd_0x60"};
        vecs[2] = '{32'h0000_0006, 32'h3344_5566, 2'b00, "rd_0x06"};
        vecs[3] = '{32'h0000_007C, 32'h0000_0000, 2'b00, "rd_0x7C"};
`ifdef AXI_STS_ADDR_CHECK_EN
        vecs[4] = '{32'h0000_0084, 32'h0000_0000, 2'b10, "rd_0x84"};
`else
        vecs[4] = '{32'h0000_0084, 32'h3344_5566, 2'b00, "rd_0x84"};
`endif

        for (int k = 0; k < WORDS; k++) words[k] = 32'd0;
        words[1]  = 32'h3344_5566;
        words[24] = 32'h1122_3344;
        areset  = 1'b1;
        araddr  = 32'd0;
        arvalid = 1'b0;
        rready  = 1'b0;

        // Reset state.
        repeat (2) @(negedge aclk);
        check("rst.rvalid", 32'(rvalid), 32'd0);
        check("rst.rdata", rdata, 32'd0);
        check("rst.rresp", 32'(rresp), 32'd0);
        check("rst.arready", 32'(arready), 32'd0);
        areset = 1'b0;

        // Directed vector table.
        foreach (vecs[i]) do_read(vecs[i].addr, vecs[i].data, vecs[i].resp, 0, 1'b0, vecs[i].name);

        // Backpressure: data frozen while word1 changes underneath.
        @(negedge aclk);
        araddr  = 32'h4;
        arvalid = 1'b1;
        @(posedge aclk);
        #1;
        araddr = 32'h60;
        words[1] = 32'hDEAD_BEEF;
        for (int h = 0; h < 5; h++) begin
            @(negedge aclk);
            check("bp.rvalid", 32'(rvalid), 32'd1);
            check("bp.rdata", rdata, 32'h3344_5566);
            check("bp.arready", 32'(arready), 32'd0);
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        @(posedge aclk);
        #1;
        rready = 1'b0;
        @(negedge aclk);
        check("bp.done_rvalid", 32'(rvalid), 32'd0);
        check("bp.arready_after", 32'(arready), 32'd1);
        do_read(32'h4, 32'hDEAD_BEEF, 2'b00, 0, 1'b0, "bp.reread");

        // Asynchronous reset while a response is pending.
        @(negedge aclk);
        araddr  = 32'h60;
        arvalid = 1'b1;
        rready  = 1'b0;
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
        @(negedge aclk);
        check("ar.rvalid_before", 32'(rvalid), 32'd1);
        #2;
        areset = 1'b1;
        #1;
        check("ar.rvalid_async", 32'(rvalid), 32'd0);
        check("ar.arready_in_rst", 32'(arready), 32'd0);
        check("ar.rdata_in_rst", rdata, 32'd0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            check("ar.no_spurious_rvalid", 32'(rvalid), 32'd0);
            check("ar.arready_after", 32'(arready), 32'd1);
        end

        // Back-to-back: arvalid held high, rready tied high.
        for (int i = 0; i < 8; i++) b2b_addr[i] = 32'($urandom_range(0, 127));
        for (int k = 0; k < WORDS; k++) words[k] = $urandom;
        rready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            araddr  = b2b_addr[i];
            arvalid = 1'b1;
            ed = model_data(b2b_addr[i]);
            check("b2b.arready", 32'(arready), 32'd1);
            @(negedge aclk);
            check("b2b.rvalid", 32'(rvalid), 32'd1);
            check("b2b.rdata", rdata, ed);
            check("b2b.arready_busy", 32'(arready), 32'd0);
            if (i == 7) arvalid = 1'b0;
        end
        @(negedge aclk);
        check("b2b.end_rvalid", 32'(rvalid), 32'd0);
        rready = 1'b0;

        // Randomized reads against the reference model.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 255));
            ed = model_data(a);
            er = model_resp(a);
            do_read(a, ed, er, $urandom_range(0, 3), 1'b1, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
